// File: rtl/dmem_responder.sv
// dmem_responder
//   Target side of the core's data-memory interface. Accepts one load/store
//   at a time over a valid/ready handshake, keeps DEPTH doublewords of
//   storage and returns a one-cycle response LATENCY cycles after acceptance.
//
// Ports
//   clk, rst            system clock, synchronous active-low reset
//   req_valid/ready     request handshake
//   req_write           1 = store, 0 = load
//   req_addr            byte address (word index = req_addr[63:3])
//   req_wdata/wmask     store data and byte enables
//   rsp_valid           one-cycle response strobe
//   rsp_rdata, rsp_err  load data / fault flag, zero outside the response
//   access_count        saturating count of non-error responses
//   debug_addr/data     combinational storage read for board inspection
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | request latched, latency counter running
// RESP  | response presented on rsp_* for one cycle
`timescale 1ns/1ps
module dmem_responder #(
  parameter int DEPTH   = 512,
  parameter int IDX_W   = 9,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [63:0]      req_addr,
  input  logic [63:0]      req_wdata,
  input  logic [7:0]       req_wmask,
  output logic             rsp_valid,
  output logic [63:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [31:0]      access_count,
  input  logic [IDX_W-1:0] debug_addr,
  output logic [63:0]      debug_data
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  lat_cnt;
  logic        lat_write;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;
  logic [7:0]  lat_wmask;

  logic [63:0] mem [DEPTH];

  logic             handshake;
  logic             commit;
  logic             cur_write;
  logic [63:0]      cur_addr;
  logic [63:0]      cur_wdata;
  logic [7:0]       cur_wmask;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_err;
  logic [63:0]      merged;

  assign handshake = req_valid && req_ready;

  // With LATENCY==1 the commit edge is the handshake edge itself, so the
  // live request fields are used; otherwise the latched copy is used.
  always_comb begin
    if (state == IDLE) begin
      cur_write = req_write;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_wmask = req_wmask;
    end else begin
      cur_write = lat_write;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
      cur_wmask = lat_wmask;
    end
  end

  assign cur_idx = cur_addr[IDX_W+2:3];
  assign cur_err = (cur_addr[2:0] != 3'b000) || (cur_addr[63:3] >= 61'(DEPTH));

  // Commit is suppressed while rst is low, so a reset on the commit edge
  // drops the write as well as the response.
  assign commit = rst && (((state == IDLE) && handshake && (LATENCY == 1)) ||
                          ((state == WAIT) && (lat_cnt == 4'd1)));

  always_comb begin
    merged = mem[cur_idx];
    for (int i = 0; i < 8; i++) begin
      if (cur_wmask[i]) merged[8*i +: 8] = cur_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (commit && cur_write && !cur_err) mem[cur_idx] <= merged;
  end

  assign debug_data = mem[debug_addr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      req_ready    <= 1'b0;
      lat_cnt      <= 4'd0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 64'd0;
      rsp_err      <= 1'b0;
      access_count <= 32'd0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 64'd0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (handshake) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wmask <= req_wmask;
            lat_cnt   <= 4'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
      if (commit) begin
        rsp_valid <= 1'b1;
        rsp_err   <= cur_err;
        rsp_rdata <= (cur_err || cur_write) ? 64'd0 : mem[cur_idx];
        if (!cur_err && (access_count != 32'hFFFF_FFFF))
          access_count <= access_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;
  localparam int DEPTH = 512;
  localparam int IDX_W = 9;
  localparam int LAT   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_valid1;
  logic             req_ready, req_ready1;
  logic             req_write;
  logic [63:0]      req_addr, req_wdata;
  logic [7:0]       req_wmask;
  logic             rsp_valid, rsp_valid1;
  logic [63:0]      rsp_rdata, rsp_rdata1;
  logic             rsp_err, rsp_err1;
  logic [31:0]      access_count, access_count1;
  logic [IDX_W-1:0] debug_addr;
  logic [63:0]      debug_data, debug_data1;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model
  logic [63:0] model_mem [DEPTH];
  logic [31:0] model_count = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .IDX_W(IDX_W), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .access_count(access_count),
    .debug_addr(debug_addr), .debug_data(debug_data));

  dmem_responder #(.DEPTH(DEPTH), .IDX_W(IDX_W), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
    .rsp_err(rsp_err1), .access_count(access_count1),
    .debug_addr(debug_addr), .debug_data(debug_data1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on dut, checked against the model. Called at/after a negedge.
  task automatic do_req(input bit wr, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [7:0] wm, output logic [63:0] got_rdata);
    int k;
    bit exp_err;
    int widx;
    logic [63:0] exp_rdata;
    k = 0;
    while (req_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    chk("ready_before_req", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wmask = wm;
    @(posedge clk);
    #1;
    // garbage after the handshake must be ignored
    req_valid = 1'b0; req_write = ~wr; req_addr = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom}; req_wmask = 8'($urandom);
    exp_err = (addr % 8 != 0) || ((addr / 8) >= 64'(DEPTH));
    widx = int'(addr / 8);
    exp_rdata = 64'd0;
    if (!exp_err) begin
      if (wr) begin
        for (int b = 0; b < 8; b++)
          if (wm[b]) model_mem[widx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        exp_rdata = model_mem[widx];
      end
      if (model_count != 32'hFFFF_FFFF) model_count = model_count + 1;
    end
    k = 0;
    do begin @(negedge clk); k++; end while (rsp_valid !== 1'b1 && k < 20);
    chk("latency", 64'(k), 64'(LAT));
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    chk("access_count", 64'(access_count), 64'(model_count));
    got_rdata = rsp_rdata;
    @(negedge clk);
    chk("rsp_valid_one_cycle", 64'(rsp_valid), 64'd0);
    chk("idle_rdata_zero", rsp_rdata, 64'd0);
    if (!exp_err) begin
      debug_addr = IDX_W'(widx);
      #1;
      chk("debug_data", debug_data, model_mem[widx]);
    end
  endtask

  // req_valid held high across three requests; records handshake and
  // response cycle numbers relative to the first handshake.
  task automatic b2b(input bit sel, input bit wr, input logic [63:0] data);
    int hs[$];
    int rs[$];
    int l;
    logic rdy, rv;
    l = sel ? 1 : LAT;
    req_write = wr; req_addr = 64'h10; req_wdata = data; req_wmask = 8'hFF;
    if (sel) req_valid1 = 1'b1; else req_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (hs.size() == 3) begin req_valid = 1'b0; req_valid1 = 1'b0; end
      rdy = sel ? req_ready1 : req_ready;
      rv  = sel ? rsp_valid1 : rsp_valid;
      if ((sel ? req_valid1 : req_valid) && rdy) hs.push_back(i);
      if (rv) begin
        rs.push_back(i);
        if (!sel) begin
          chk("b2b_rdata", rsp_rdata, model_mem[2]);
          if (model_count != 32'hFFFF_FFFF) model_count = model_count + 1;
          chk("b2b_count", 64'(access_count), 64'(model_count));
        end else begin
          chk("b2b1_rdata", rsp_rdata1, 64'd0);
          chk("b2b1_err", 64'(rsp_err1), 64'd0);
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0; req_valid1 = 1'b0;
    chk("b2b_hs_count", 64'(hs.size()), 64'd3);
    chk("b2b_rs_count", 64'(rs.size()), 64'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < hs.size()) chk("b2b_hs_cycle", 64'(hs[k]), 64'(k * (l + 1)));
      if (k < rs.size()) chk("b2b_rs_cycle", 64'(rs[k]), 64'(k * (l + 1) + l));
    end
  endtask

  initial begin
    logic [63:0] r;
    logic [63:0] addr;
    logic [63:0] d4;
    int sel;
    rst = 1'b0; req_valid = 1'b0; req_valid1 = 1'b0; req_write = 1'b0;
    req_addr = 64'd0; req_wdata = 64'd0; req_wmask = 8'd0; debug_addr = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    chk("rst_count", 64'(access_count), 64'd0);
    chk("rst_count1", 64'(access_count1), 64'd0);
    chk("rst_rdata1", rsp_rdata1, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(req_ready), 64'd1);

    // fill storage so every location is known
    for (int i = 0; i < DEPTH; i++)
      do_req(1'b1, 64'(i) * 8, {$urandom, $urandom}, 8'hFF, r);

    // store then load
    do_req(1'b1, 64'h10, 64'h1122334455667788, 8'hFF, r);
    do_req(1'b0, 64'h10, 64'd0, 8'h00, r);
    chk("tp_load", r, 64'h1122334455667788);

    // byte mask, then empty mask
    do_req(1'b1, 64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, r);
    do_req(1'b0, 64'h10, 64'd0, 8'h00, r);
    chk("tp_mask", r, 64'h11223344AAAAAAAA);
    do_req(1'b1, 64'h10, 64'h5555555555555555, 8'h00, r);
    do_req(1'b0, 64'h10, 64'd0, 8'h00, r);
    chk("tp_mask0", r, 64'h11223344AAAAAAAA);

    // faults: misaligned and out of range
    do_req(1'b0, 64'h14, 64'd0, 8'h00, r);
    do_req(1'b1, 64'h1000, 64'hDEADBEEFDEADBEEF, 8'hFF, r);
    debug_addr = '0; #1;
    chk("oob_no_write", debug_data, model_mem[0]);
    do_req(1'b1, 64'hFFFF_0000_0000_0008, 64'h1, 8'hFF, r);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      sel = int'($urandom_range(0, 9));
      addr = 64'($urandom_range(0, DEPTH - 1)) * 8;
      if (sel == 0) addr = addr | 64'($urandom_range(1, 7));
      else if (sel == 1) addr = {32'($urandom), 32'($urandom)} | 64'h1000;
      do_req(1'($urandom), addr, {$urandom, $urandom}, 8'($urandom), r);
    end

    // back-to-back with continuous valid
    @(negedge clk);
    b2b(1'b0, 1'b0, 64'd0);
    b2b(1'b1, 1'b1, 64'hCAFEF00D12345678);
    debug_addr = IDX_W'(2); #1;
    chk("b2b1_debug", debug_data1, 64'hCAFEF00D12345678);

    // reset in the WAIT cycle drops the store
    @(negedge clk);
    d4 = model_mem[4];
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20;
    req_wdata = ~d4; req_wmask = 8'hFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midrst_ready", 64'(req_ready), 64'd0);
    end
    debug_addr = IDX_W'(4); #1;
    chk("midrst_no_write", debug_data, d4);
    rst = 1'b1;
    model_count = 0;
    @(negedge clk);
    chk("midrst_ready_after", 64'(req_ready), 64'd1);
    chk("midrst_rsp_after", 64'(rsp_valid), 64'd0);
    chk("midrst_count", 64'(access_count), 64'd0);

    // saturation
    force dut.access_count = 32'hFFFF_FFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.access_count;
    @(negedge clk);
    model_count = 32'hFFFF_FFFE;
    chk("sat_preset", 64'(access_count), 64'(model_count));
    do_req(1'b1, 64'h30, 64'h0123456789ABCDEF, 8'hFF, r);
    do_req(1'b0, 64'h30, 64'd0, 8'h00, r);
    do_req(1'b0, 64'h38, 64'd0, 8'h00, r);
    chk("sat_final", 64'(access_count), 64'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target side of the core's data-memory interface (address, write data, write strobe).
- Accepts one load/store request at a time over a valid/ready handshake, holds doubleword storage, and returns a single-cycle response after a fixed, parameterised latency.
- Carries a debug read port, matching the core's debug register port, so the board can inspect memory contents.

Parameters:
- DEPTH, 512, number of 64-bit words in storage; word index = req_addr[63:3].
- IDX_W, 9, width of the debug word index; must equal clog2(DEPTH).
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  64  byte address.
- req_wdata  input  64  store data.
- req_wmask  input  8  store byte enables; bit i enables req_wdata[8i+7:8i].
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  64  load data; 0 for stores and errors.
- rsp_err  output  1  request faulted; qualified by rsp_valid.
- access_count  output  32  count of successful responses, saturating.
- debug_addr  input  IDX_W  debug word index.
- debug_data  output  64  combinational read of storage[debug_addr].

Behaviour:
- Reset (rst==0 at an edge):
  - FSM goes to IDLE; req_ready=0 while rst is low.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, access_count=0.
  - Storage contents are NOT cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. Handshake = req_valid & req_ready at an edge. On handshake, latch write, addr, wdata and wmask, and load the latency counter with LATENCY-1. Go to RESP if LATENCY==1, else go to WAIT.
  - WAIT: req_ready=0. Counter decrements each cycle; at the edge where counter==1, go to RESP.
  - RESP: req_ready=0, rsp_valid=1 for exactly this cycle, then go to IDLE. There is no response backpressure.
- Timing:
  - Handshake at edge T → rsp_valid high in cycle T+LATENCY.
  - req_ready is high again in cycle T+LATENCY+1.
  - Maximum throughput is one request per LATENCY+1 cycles.
  - req_* inputs are ignored outside the handshake edge; latched values are used.
- Error check (on latched values): error if addr[2:0]!=0 (misaligned) OR addr[63:3] >= DEPTH (out of range).
  - On error: rsp_err=1, rsp_rdata=0, no storage write, access_count unchanged.
- Commit happens on the edge entering RESP, so outputs are registered and valid during RESP.
  - Load: rsp_rdata = storage[idx].
  - Store: storage[idx] byte i ← wdata byte i where wmask[i]=1; other bytes keep their value. rsp_rdata=0.
  - wmask==0 store: no change, but still a normal response (rsp_err=0, counted).
- access_count increments by 1 on each non-error response and saturates at 0xFFFFFFFF without wrapping.
- Outside RESP: rsp_rdata, rsp_err and rsp_valid are held at 0.
- debug_data is a combinational read of storage. It reflects a store from the cycle after the commit edge, and is unaffected by reset.
- Reset mid-operation (WAIT or RESP): the in-flight request is dropped, no write commits if reset is asserted on the commit edge, and no response is issued.
- req_valid held high continuously: a new request is accepted each time the FSM is in IDLE. There are no duplicate acceptances.

Test Plan:
- Store then load: store addr 0x10, wdata 0x1122334455667788, mask 0xFF. Then load addr 0x10. Required: each rsp_valid arrives exactly 2 cycles after its handshake; load rsp_rdata=0x1122334455667788, rsp_err=0, access_count=2, debug_data at index 2 matches.
- Byte mask: location 0x10 holds 0x1122334455667788. Store wdata 0xAAAAAAAAAAAAAAAA, mask 0x0F, then load. Required: rsp_rdata=0x11223344AAAAAAAA. Then store with mask 0x00 and load again: data unchanged, count increments.
- Errors: load addr 0x14 → rsp_err=1, rdata=0. Store addr 0x1000 with DEPTH=512 → rsp_err=1 and storage unchanged. access_count unchanged in both cases.
- Reset mid-op: handshake a store at addr 0x20, assert rst=0 in the WAIT cycle. Required: no rsp_valid, storage[4] unchanged, req_ready=0 during reset, req_ready=1 in the first cycle after rst=1.
- Back-to-back: hold req_valid=1 for 3 loads with LATENCY=2. Required: handshakes at cycles 0, 3, 6; rsp_valid at cycles 2, 5, 8. Repeat with LATENCY=1: handshakes every 2 cycles.
- Saturation: force access_count to 0xFFFFFFFE (or run a long directed loop), then perform 2 successful accesses. Required: count reads 0xFFFFFFFF and stays there.
